l2_fill_responder: RTL and testbench
====================================

// Module: l2_fill_responder
// PURPOSE
//  Next-level (L2) responder for L1 line-fill requests. The L1 caches issue 26-bit
//  line addresses (byte address [31:6]) on a miss. This block sits behind those caches.
//  It queues requests in a FIFO and looks each one up in a direct-mapped L2 tag store.
//  It models hit or miss latency, then returns the line address with a hit flag.
//  It also maintains read/hit/miss statistics for the statistics module.
// PARAMETERS
//  DEPTH          4   request FIFO entries; power of 2, >=2
//  L2_INDEX_BITS  8   L2 index width; 2**L2_INDEX_BITS direct-mapped lines, 1..25
//  HIT_LAT        2   WAIT-state cycles on an L2 hit; >=1
//  MISS_LAT       10  WAIT-state cycles on an L2 miss; >=1
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  rst        in   1   synchronous reset, active-high
//  req_valid  in   1   L1 presents a fill request
//  req_addr   in   26  line address; index=[L2_INDEX_BITS-1:0], tag=[25:L2_INDEX_BITS]
//  req_ready  out  1   FIFO not full; request accepted on edge where valid&&ready
//  resp_valid out  1   response presented
//  resp_addr  out  26  line address of the response
//  resp_hit   out  1   1 = request hit in L2, 0 = miss (line now allocated)
//  resp_ready in   1   L1 accepts response on edge where valid&&ready
//  reads      out  32  lookups performed
//  hits       out  32  L2 hits
//  misses     out  32  L2 misses
//  busy       out  1   FSM not IDLE or FIFO not empty
// BEHAVIOUR
//  Reset: FIFO emptied, FSM->IDLE, all L2 valid bits cleared in one cycle.
//   reads/hits/misses=0, resp_valid=0, resp_addr=0, resp_hit=0, busy=0.
//   Reset mid-operation aborts the in-flight request and drops queued ones; no response.
//   rst has priority over every other event in the same cycle.
//  req_ready = (fifo_count != DEPTH), combinational from registered count.
//   When full, no push even if a pop occurs the same cycle.
//  FIFO is in-order. Push and pop in the same cycle are legal when not full; count unchanged.
//  FSM states and transitions:
//   IDLE:   FIFO non-empty -> pop head into cur_addr, go LOOKUP.
//   LOOKUP: one cycle; reads+=1.
//     valid[idx] && tag[idx]==cur_tag -> hit: hits+=1, cur_hit=1, cnt=HIT_LAT-1.
//     Otherwise -> miss: misses+=1, write tag, set valid, cur_hit=0, cnt=MISS_LAT-1.
//     Then go WAIT.
//   WAIT:   cnt==0 -> RESP; otherwise cnt-=1. Lasts exactly LAT cycles.
//   RESP:   resp_valid=1; resp_addr=cur_addr; resp_hit=cur_hit; all held stable until
//     resp_ready. On the handshake edge go IDLE; resp_valid is 0 the next cycle.
//  Latency: request accepted at edge E into an empty, idle block ->
//   resp_valid first high after edge E+LAT+3.
//  Single outstanding lookup. Back-to-back requests are serialised, and the next pop
//   occurs in the IDLE cycle after the RESP handshake.
//  Counters are 32-bit and wrap modulo 2**32 with no saturation.
//  Tag store is written only on a miss. A miss overwrites the indexed line
//   unconditionally; there is no dirty or writeback model.
//  busy = (state!=IDLE) || (fifo_count!=0).
// TESTING
//  1 rst, then req 26'h0000040 -> resp_valid after edge E+13, resp_hit=0, misses=1, reads=1.
//  2 same 26'h0000040 again -> resp after E+5, resp_hit=1, hits=1, reads=2.
//  3 alternate 26'h0000100 and 26'h0000200 (both idx 0x00) x4 -> all resp_hit=0, misses=4.
//  4 resp_ready=0, 6 back-to-back reqs -> 5 accepted, then req_ready=0.
//    Then resp_ready=1 -> 5 responses, in order.
//  5 rst asserted during WAIT of a miss -> next cycle resp_valid=0, busy=0, counters 0.
//    Re-request the same address -> miss.
//  6 resp_ready low 10 cycles in RESP -> resp_valid/resp_addr/resp_hit stable.
//    Single pulse -> resp_valid drops next cycle.

Source files
------------

// File: rtl/l2_fill_responder.sv
// L2 line-fill responder: queues L1 miss requests, looks them up in a direct-mapped
// tag store, models hit/miss latency and returns the line address with a hit flag.
module l2_fill_responder #(
   parameter int DEPTH         = 4,
   parameter int L2_INDEX_BITS = 8,
   parameter int HIT_LAT       = 2,
   parameter int MISS_LAT      = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [25:0] req_addr,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [25:0] resp_addr,
   output logic        resp_hit,
   input  logic        resp_ready,
   output logic [31:0] reads,
   output logic [31:0] hits,
   output logic [31:0] misses,
   output logic        busy
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int NLINES  = 1 << L2_INDEX_BITS;
   localparam int TAG_W   = 26 - L2_INDEX_BITS;
   localparam int MAX_LAT = (HIT_LAT > MISS_LAT) ? HIT_LAT : MISS_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT, S_RESP} state_t;

   state_t             state_q;
   logic [25:0]        fifo_mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]     count_q, count_d;
   logic [25:0]        cur_addr_q;
   logic               cur_hit_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [TAG_W-1:0]   tag_q [NLINES];
   logic [NLINES-1:0]  valid_q;
   logic               resp_valid_q, resp_hit_q;
   logic [25:0]        resp_addr_q;
   logic [31:0]        reads_q, hits_q, misses_q;

   logic                     push, pop, lookup_hit;
   logic [L2_INDEX_BITS-1:0] cur_idx;
   logic [TAG_W-1:0]         cur_tag;

   assign req_ready  = (count_q != DEPTH[PTR_W:0]);
   assign push       = req_valid && req_ready;
   assign pop        = (state_q == S_IDLE) && (count_q != '0);
   assign cur_idx    = cur_addr_q[L2_INDEX_BITS-1:0];
   assign cur_tag    = cur_addr_q[25:L2_INDEX_BITS];
   assign lookup_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

   always_comb begin
      // NOTE: default first so every path assigns count_d and no latch is inferred.
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: storage arrays carry no reset; pointers and valid bits make stale contents unreachable.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= req_addr;
      if (!rst && state_q == S_LOOKUP && !lookup_hit) tag_q[cur_idx] <= cur_tag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cur_addr_q   <= '0;
         cur_hit_q    <= 1'b0;
         cnt_q        <= '0;
         valid_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_addr_q  <= '0;
         resp_hit_q   <= 1'b0;
         reads_q      <= '0;
         hits_q       <= '0;
         misses_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  cur_addr_q <= fifo_mem_q[rd_ptr_q];
                  state_q    <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               reads_q <= reads_q + 32'd1;
               if (lookup_hit) begin
                  hits_q    <= hits_q + 32'd1;
                  cur_hit_q <= 1'b1;
                  cnt_q     <= CNT_W'(HIT_LAT - 1);
               end else begin
                  misses_q         <= misses_q + 32'd1;
                  valid_q[cur_idx] <= 1'b1;
                  cur_hit_q        <= 1'b0;
                  cnt_q            <= CNT_W'(MISS_LAT - 1);
               end
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == '0) state_q <= S_RESP;
               else             cnt_q   <= cnt_q - CNT_W'(1);
            end
            S_RESP: begin
               // First RESP cycle loads the output registers; they then hold until accepted.
               if (!resp_valid_q) begin
                  resp_valid_q <= 1'b1;
                  resp_addr_q  <= cur_addr_q;
                  resp_hit_q   <= cur_hit_q;
               end else if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_addr  = resp_addr_q;
   assign resp_hit   = resp_hit_q;
   assign reads      = reads_q;
   assign hits       = hits_q;
   assign misses     = misses_q;
   assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_l2_fill_responder.sv
// Directed bench for l2_fill_responder: a tag-store model predicts hit/miss at request
// acceptance and a scoreboard queue checks responses in order as they are handed off.
module tb_l2_fill_responder;

   localparam int IDX = 8;

   logic        clk = 1'b0;
   logic        rst, req_valid, resp_ready;
   logic [25:0] req_addr;
   logic        req_ready, resp_valid, resp_hit, busy;
   logic [25:0] resp_addr;
   logic [31:0] reads, hits, misses;

   int n_checks = 0;
   int n_fails  = 0;

   logic [26:0]       sb_q [$];
   logic [25-IDX:0]   m_tag   [1 << IDX];
   logic              m_valid [1 << IDX];

   l2_fill_responder #(.DEPTH(4), .L2_INDEX_BITS(IDX), .HIT_LAT(2), .MISS_LAT(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_hit(resp_hit),
      .resp_ready(resp_ready),
      .reads(reads), .hits(hits), .misses(misses), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < (1 << IDX); i++) m_valid[i] = 1'b0;
      sb_q.delete();
   endtask

   task automatic sb_push(input logic [25:0] a);
      logic hit;
      hit = m_valid[a[IDX-1:0]] && (m_tag[a[IDX-1:0]] == a[25:IDX]);
      if (!hit) begin
         m_valid[a[IDX-1:0]] = 1'b1;
         m_tag[a[IDX-1:0]]   = a[25:IDX];
      end
      sb_q.push_back({hit, a});
   endtask

   // Response monitor: a handshake seen at the falling edge completes on the next rise.
   always @(negedge clk) begin
      if (!rst && resp_valid && resp_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_resp", {6'd0, resp_addr}, 32'hFFFF_FFFF);
         end else begin
            check("resp_addr", {6'd0, resp_addr}, {6'd0, sb_q[0][25:0]});
            check("resp_hit", {31'd0, resp_hit}, {31'd0, sb_q[0][26]});
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
   endtask

   task automatic send(input logic [25:0] a);
      bit done = 0;
      req_addr  = a;
      req_valid = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk); #1;
            sb_push(a);
            done = 1;
         end else begin
            @(posedge clk); #1;
         end
      end
      req_valid = 1'b0;
      check("send_accepted", {31'd0, done}, 32'd1);
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int n = 0; n < 500 && !done; n++) begin
         @(posedge clk); #1;
         if (!busy && sb_q.size() == 0) done = 1;
      end
      check("wait_idle", {31'd0, done}, 32'd1);
   endtask

   task automatic resp_latency(input string tag, input int exp_lat);
      int lat = 0;
      bit seen = 0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(posedge clk); #1;
         lat++;
         if (resp_valid) seen = 1;
      end
      check(tag, lat, exp_lat);
   endtask

   initial begin
      int accepted;
      logic [25:0] burst [6];
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
      model_clear();
      do_reset();

      // Reset state
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_addr", {6'd0, resp_addr}, 32'd0);
      check("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_reads", reads, 32'd0);
      check("rst_hits", hits, 32'd0);
      check("rst_misses", misses, 32'd0);

      // Cold miss then hit on the same line, with latency measured from acceptance
      send(26'h0000040);
      resp_latency("miss_latency", 13);
      wait_idle();
      check("t1_misses", misses, 32'd1);
      check("t1_reads", reads, 32'd1);
      send(26'h0000040);
      resp_latency("hit_latency", 5);
      wait_idle();
      check("t2_hits", hits, 32'd1);
      check("t2_reads", reads, 32'd2);

      // Conflicting tags on index 0 evict each other every time
      do_reset();
      for (int i = 0; i < 4; i++) send((i % 2 == 0) ? 26'h0000100 : 26'h0000200);
      wait_idle();
      check("t3_misses", misses, 32'd4);
      check("t3_hits", hits, 32'd0);
      check("t3_reads", reads, 32'd4);

      // Back-pressure: one in flight plus a full FIFO, then drain in order
      resp_ready = 1'b0;
      burst[0] = 26'h0000200; burst[1] = 26'h0001005; burst[2] = 26'h0001005;
      burst[3] = 26'h0000100; burst[4] = 26'h3FFFFFF; burst[5] = 26'h0000077;
      accepted = 0;
      req_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_addr = burst[accepted];
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk); #1;
            sb_push(burst[accepted]);
            accepted++;
         end else begin
            @(posedge clk); #1;
         end
      end
      req_valid = 1'b0;
      check("t4_accepted", accepted, 32'd5);
      check("t4_full_ready", {31'd0, req_ready}, 32'd0);
      resp_ready = 1'b1;
      wait_idle();
      check("t4_reads", reads, 32'd9);

      // Reset in the middle of a miss's wait period
      do_reset();
      send(26'h0003ABC);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("t5_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_reads", reads, 32'd0);
      check("t5_misses", misses, 32'd0);
      rst = 1'b0;
      model_clear();
      send(26'h0003ABC);
      wait_idle();
      check("t5_rereq_misses", misses, 32'd1);
      check("t5_rereq_hits", hits, 32'd0);

      // Response held stable under a stalled consumer, then a single-cycle accept
      resp_ready = 1'b0;
      send(26'h0000040);
      begin
         bit seen = 0;
         for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1;
         end
         check("t6_resp_seen", {31'd0, seen}, 32'd1);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("t6_hold_valid", {31'd0, resp_valid}, 32'd1);
         check("t6_hold_addr", {6'd0, resp_addr}, {6'd0, sb_q[0][25:0]});
         check("t6_hold_hit", {31'd0, resp_hit}, {31'd0, sb_q[0][26]});
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("t6_drop_valid", {31'd0, resp_valid}, 32'd0);
      check("t6_sb_empty", sb_q.size(), 32'd0);
      @(posedge clk); #1;
      check("t6_busy", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
